// File: rtl/ongorucu.sv
// Bimodal branch direction predictor: 2-bit saturating counters indexed by PC, trained by execute.
// Latency: prediction is combinational (0 cycles); training writes land on the next rising clk edge.
// Backpressure: none; every valid fetch is answered, and each yurut_gecerli cycle is one update.
module ongorucu #(
  parameter int IDX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] getir_ps,
  input  logic [31:0] getir_buyruk,
  input  logic        getir_gecerli,
  input  logic [31:0] yurut_ps,
  input  logic [31:0] yurut_buyruk,
  input  logic        yurut_dallan,
  input  logic [31:0] yurut_dallan_ps,
  input  logic        yurut_gecerli,
  output logic        sonuc_dallan,
  output logic [31:0] sonuc_dallan_ps
);

  localparam int          ENTRIES = 1 << IDX_BITS;
  localparam logic [6:0]  OP_B    = 7'b1100011;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [1:0]  CTR_RST = 2'b01;

  // 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; bit 1 is the direction.
  logic [1:0] ctr [ENTRIES];

  logic [IDX_BITS-1:0] getir_idx;
  logic [IDX_BITS-1:0] yurut_idx;
  logic                getir_b;
  logic                getir_jal;
  logic [31:0]         b_imm;
  logic [31:0]         j_imm;
  logic                guncelle;

  // The resolved target and the PC/instruction bits above the index do not
  // influence the table; fold them here so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{yurut_dallan_ps, yurut_ps[31:IDX_BITS+2], yurut_ps[1:0],
                         yurut_buyruk[31:7]};

  assign getir_idx = getir_ps[IDX_BITS+1:2];
  assign yurut_idx = yurut_ps[IDX_BITS+1:2];

  // Only resolved conditional branches train; JAL and everything else are ignored.
  assign guncelle = yurut_gecerli && (yurut_buyruk[6:0] == OP_B);

  // Decode the fetched word and form the predicted direction and target.
  always_comb begin
    getir_b         = (getir_buyruk[6:0] == OP_B);
    getir_jal       = (getir_buyruk[6:0] == OP_JAL);
    b_imm           = {{20{getir_buyruk[31]}}, getir_buyruk[7], getir_buyruk[30:25],
                       getir_buyruk[11:8], 1'b0};
    j_imm           = {{12{getir_buyruk[31]}}, getir_buyruk[19:12], getir_buyruk[20],
                       getir_buyruk[30:21], 1'b0};
    sonuc_dallan    = 1'b0;
    sonuc_dallan_ps = getir_ps + 32'd4;
    if (getir_b) begin
      // Target is driven even when the counter says not-taken.
      sonuc_dallan_ps = getir_ps + b_imm;
      sonuc_dallan    = getir_gecerli && ctr[getir_idx][1];
    end else if (getir_jal) begin
      sonuc_dallan_ps = getir_ps + j_imm;
      sonuc_dallan    = getir_gecerli;
    end
  end

  // Counter table: reset to weak not-taken (wins over training), else saturate toward the outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_RST;
      end
    end else if (guncelle) begin
      if (yurut_dallan) begin
        if (ctr[yurut_idx] != 2'b11) ctr[yurut_idx] <= ctr[yurut_idx] + 2'b01;
      end else begin
        if (ctr[yurut_idx] != 2'b00) ctr[yurut_idx] <= ctr[yurut_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_ongorucu.sv
// Bench for the bimodal predictor: drives one fetch/execute pair per cycle and scoreboards the prediction.
// Latency: expected outputs are pushed when a cycle is driven and compared at the following falling edge.
// Backpressure: none in the DUT; every driven cycle produces exactly one observed prediction.
module tb_ongorucu;

  localparam logic [31:0] BEQ8  = 32'h0000_0463;  // beq +8
  localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;  // beq -8
  localparam logic [31:0] JAL16 = 32'h0100_006F;  // jal +16
  localparam logic [31:0] ADDI  = 32'h0000_0013;  // nop
  localparam logic [31:0] JALR  = 32'h0000_80E7;  // jalr

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] getir_ps, getir_buyruk, yurut_ps, yurut_buyruk, yurut_dallan_ps;
  logic        getir_gecerli, yurut_dallan, yurut_gecerli;
  logic        sonuc_dallan;
  logic [31:0] sonuc_dallan_ps;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        d;
    logic [31:0] ps;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ongorucu #(.IDX_BITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .getir_ps        (getir_ps),
    .getir_buyruk    (getir_buyruk),
    .getir_gecerli   (getir_gecerli),
    .yurut_ps        (yurut_ps),
    .yurut_buyruk    (yurut_buyruk),
    .yurut_dallan    (yurut_dallan),
    .yurut_dallan_ps (yurut_dallan_ps),
    .yurut_gecerli   (yurut_gecerli),
    .sonuc_dallan    (sonuc_dallan),
    .sonuc_dallan_ps (sonuc_dallan_ps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive fetch/execute/reset, optionally queue an expectation,
  // compare at the falling edge, then let the rising edge commit any write.
  task automatic step(input logic r,
                      input logic [31:0] fps, input logic [31:0] finst, input logic fv,
                      input logic [31:0] yps, input logic [31:0] yinst, input logic yd,
                      input logic yv,
                      input logic check, input string tag, input logic ed,
                      input logic [31:0] eps);
    exp_t e;
    rst           = r;
    getir_ps      = fps;
    getir_buyruk  = finst;
    getir_gecerli = fv;
    yurut_ps      = yps;
    yurut_buyruk  = yinst;
    yurut_dallan  = yd;
    yurut_dallan_ps = yps + 32'd8;
    yurut_gecerli = yv;
    if (check) begin
      e.tag = tag; e.d = ed; e.ps = eps;
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".dir"}, {31'd0, sonuc_dallan}, {31'd0, e.d});
      chk({e.tag, ".tgt"}, sonuc_dallan_ps, e.ps);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ps, input logic [31:0] inst,
                       input logic v, input logic ed, input logic [31:0] eps);
    step(1'b0, ps, inst, v, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, tag, ed, eps);
  endtask

  // Execute-side update with an idle (invalid) fetch of a nop at PC 0.
  task automatic upd(input logic [31:0] ps, input logic [31:0] inst, input logic taken);
    step(1'b0, 32'd0, ADDI, 1'b0, ps, inst, taken, 1'b1, 1'b1, "idle", 1'b0, 32'h4);
  endtask

  task automatic do_reset();
    step(1'b1, 32'd0, ADDI, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "", 1'b0, 32'd0);
  endtask

  initial begin
    #1;
    do_reset();
    do_reset();

    // Reset default and training up/down.
    fetch("rst_default", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);
    upd(32'h100, BEQ8, 1'b1);
    fetch("train_1T", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);
    upd(32'h100, BEQ8, 1'b1);
    fetch("train_2T", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);
    upd(32'h100, BEQ8, 1'b0);
    fetch("train_1NT", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);
    upd(32'h100, BEQ8, 1'b0);
    fetch("train_2NT", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);

    // Upper saturation: from 01, five taken reach 11 and must not wrap.
    for (int i = 0; i < 5; i++) upd(32'h100, BEQ8, 1'b1);
    upd(32'h100, BEQ8, 1'b0);
    fetch("sat_hi_1NT", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);
    upd(32'h100, BEQ8, 1'b0);
    fetch("sat_hi_2NT", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);

    // Lower saturation: three not-taken floor at 00, two taken needed.
    do_reset();
    for (int i = 0; i < 3; i++) upd(32'h100, BEQ8, 1'b0);
    upd(32'h100, BEQ8, 1'b1);
    fetch("sat_lo_1T", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);
    upd(32'h100, BEQ8, 1'b1);
    fetch("sat_lo_2T", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);

    // Backward branch, JAL, JAL on execute, aliasing, neighbouring index.
    do_reset();
    fetch("beq_back", 32'h200, BEQM8, 1'b1, 1'b0, 32'h1F8);
    fetch("jal_fwd", 32'h300, JAL16, 1'b1, 1'b1, 32'h310);
    upd(32'h100, JAL16, 1'b1);
    fetch("jal_no_train", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);
    upd(32'h100, ADDI, 1'b1);
    fetch("nop_no_train", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);
    upd(32'h500, BEQ8, 1'b1);
    fetch("alias", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);
    fetch("neighbour", 32'h104, BEQ8, 1'b1, 1'b0, 32'h10C);

    // Non-branch, JALR and invalid slots.
    fetch("nonbranch", 32'h400, ADDI, 1'b1, 1'b0, 32'h404);
    fetch("jalr", 32'h600, JALR, 1'b1, 1'b0, 32'h604);
    fetch("inv_beq", 32'h100, BEQ8, 1'b0, 1'b0, 32'h108);
    fetch("inv_jal", 32'h300, JAL16, 1'b0, 1'b0, 32'h310);

    // Same-cycle read/write: prediction sees the old counter value.
    do_reset();
    step(1'b0, 32'h100, BEQ8, 1'b1, 32'h100, BEQ8, 1'b1, 1'b1,
         1'b1, "rw_same", 1'b0, 32'h108);
    fetch("rw_next", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);

    // Reset beats a simultaneous update; outputs still track the table during reset.
    step(1'b1, 32'h100, BEQ8, 1'b1, 32'h100, BEQ8, 1'b1, 1'b1,
         1'b1, "rst_live", 1'b1, 32'h108);
    fetch("rst_prio", 32'h100, BEQ8, 1'b1, 1'b0, 32'h108);
    upd(32'h100, BEQ8, 1'b1);
    fetch("rst_is_01", 32'h100, BEQ8, 1'b1, 1'b1, 32'h108);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
